// File: rtl/bcd_counter_pkg.sv
// Shared constants for the multi-digit BCD counter and its display path.
//   SEG_0..SEG_9, SEG_BLANK : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   BCD_MAX                 : largest legal BCD digit
//   clamp_bcd(d)            : maps an out-of-range digit (10..15) to 0
package bcd_counter_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_counter_mux_decode.sv
// Combinational BCD to 7-segment decoder (common anode, active-low).
//   digit : 4-bit BCD digit; codes 10..15 produce a blank display
//   seg   : segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_seg_decode
  import bcd_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_mux.sv
// Multi-digit up/down BCD counter driving a time-multiplexed common-anode
// 7-segment display.
//   clk      : board clock, all state on its rising edge
//   reset    : asynchronous active-high clear
//   cnt_en   : qualifies count ticks; value holds when low
//   up_dn    : 1 = increment, 0 = decrement
//   load     : synchronous load strobe (highest priority), restarts the tick prescaler
//   load_val : BCD value to load, digit 0 in [3:0]; digits > 9 load as 0
//   value    : registered BCD count
//   carry    : one-clk pulse, registered with the value that wrapped/borrowed
//   seg      : active-low {g,f,e,d,c,b,a} for the scanned digit
//   en       : active-low one-hot digit enable, changes on the same edge as seg
module bcd_counter_mux
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     en
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  // ---------------- tick prescaler ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tick_cnt <= '0;
    else if (load || tick) tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- per-digit carry chain ----------------
  // Carry/borrow into digit i is "every lower digit is saturated" (all 9s
  // going up, all 0s going down). Illegal digits are clamped to 0 first, so
  // they recover on the next count.
  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   at_min;
  logic [4*DIGITS-1:0] next_val;
  logic [4*DIGITS-1:0] load_clean;
  logic                wrap;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGITS-1:0] LOW_MASK = DIGITS'((64'd1 << i) - 64'd1);
    logic [3:0] cur;
    logic       cin;

    assign cur        = clamp_bcd(value[4*i +: 4]);
    assign at_max[i]  = (cur == BCD_MAX);
    assign at_min[i]  = (cur == 4'd0);
    assign cin        = up_dn ? &(at_max | ~LOW_MASK) : &(at_min | ~LOW_MASK);
    assign load_clean[4*i +: 4] = clamp_bcd(load_val[4*i +: 4]);

    always_comb begin
      next_val[4*i +: 4] = cur;
      if (cin) begin
        if (up_dn) next_val[4*i +: 4] = at_max[i] ? 4'd0    : cur + 4'd1;
        else       next_val[4*i +: 4] = at_min[i] ? BCD_MAX : cur - 4'd1;
      end
    end
  end

  assign wrap = up_dn ? &at_max : &at_min;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      carry <= 1'b0;
    end else if (load) begin
      value <= load_clean;
      carry <= 1'b0;
    end else if (tick && cnt_en) begin
      value <= next_val;
      carry <= wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  // ---------------- display scan ----------------
  logic [SW-1:0]     scan_cnt;
  logic [IW-1:0]     scan_idx;
  logic              scan_wrap;
  logic [3:0]        scan_digit;
  logic [6:0]        seg_dec;
  logic [DIGITS-1:0] en_next;

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap)
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end
  end

  always_comb begin
    scan_digit = 4'd0;
    en_next    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        scan_digit = value[4*k +: 4];
        en_next[k] = 1'b0;
      end
    end
  end

  bcd_seg_decode u_decode (
    .digit (scan_digit),
    .seg   (seg_dec)
  );

  // seg and en are registered together so the pins switch on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en  <= ~DIGITS'(1);
      seg <= SEG_0;
    end else begin
      en  <= en_next;
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux.sv
module tb_bcd_counter_mux;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT (DIGITS=3) ----------------
  logic        cnt_en, up_dn, load;
  logic [11:0] load_val;
  logic [11:0] value;
  logic        carry;
  logic [6:0]  seg;
  logic [2:0]  en;

  bcd_counter_mux #(.DIGITS(3), .TICK_DIV(4), .SCAN_DIV(2)) u_dut (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .value(value), .carry(carry), .seg(seg), .en(en)
  );

  // Single-digit instance, ticking every clk, scanning every clk.
  logic [3:0] value1;
  logic       carry1;
  logic [6:0] seg1;
  logic [0:0] en1;

  bcd_counter_mux #(.DIGITS(1), .TICK_DIV(1), .SCAN_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .cnt_en(1'b1), .up_dn(1'b1), .load(1'b0),
    .load_val(4'h0), .value(value1), .carry(carry1), .seg(seg1), .en(en1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [11:0] val;
    logic        carry;
    logic [2:0]  en;
    logic [6:0]  seg;
    logic [3:0]  val1;
    logic        carry1;
    logic        en1;
    logic [6:0]  seg1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic carry_seen;

  // reference model state (decimal integers)
  int m_tick, m_val, m_carry, m_scan, m_idx, m1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int k);
    int r;
    r = v;
    for (int j = 0; j < k; j++) r = r / 10;
    return r % 10;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [11:0] lv);
    int r;
    int n;
    r = 0;
    for (int k = 2; k >= 0; k--) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 0;
      r = r * 10 + n;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_val = 0; m_carry = 0; m_scan = 0; m_idx = 0; m1 = 0;
  endtask

  // One clock: predict, push, advance, pop, compare.
  task automatic cycle();
    exp_t e;
    bit   tick;
    tick   = (m_tick == 3);
    e.en   = ~(3'b001 << m_idx);
    e.seg  = seg_of(digit_of(m_val, m_idx));
    e.en1  = 1'b0;
    e.seg1 = seg_of(m1);
    if (load) begin
      m_val = from_load(load_val); m_carry = 0; m_tick = 0;
    end else begin
      m_tick = tick ? 0 : m_tick + 1;
      if (tick && cnt_en) begin
        if (up_dn) begin m_carry = (m_val == 999) ? 1 : 0; m_val = (m_val + 1) % 1000; end
        else       begin m_carry = (m_val == 0) ? 1 : 0;   m_val = (m_val + 999) % 1000; end
      end else begin
        m_carry = 0;
      end
    end
    if (m_scan == 1) begin m_scan = 0; m_idx = (m_idx + 1) % 3; end
    else m_scan = m_scan + 1;
    e.carry1 = (m1 == 9);
    m1       = (m1 + 1) % 10;
    e.val1   = 4'(m1);
    e.val    = to_bcd(m_val);
    e.carry  = m_carry[0];
    exp_q.push_back(e);

    @(posedge clk); #1;

    e = exp_q.pop_front();
    check("value",  32'(value),  32'(e.val));
    check("carry",  32'(carry),  32'(e.carry));
    check("en",     32'(en),     32'(e.en));
    check("seg",    32'(seg),    32'(e.seg));
    check("value1", 32'(value1), 32'(e.val1));
    check("carry1", 32'(carry1), 32'(e.carry1));
    check("en1",    32'(en1),    32'(e.en1));
    check("seg1",   32'(seg1),   32'(e.seg1));
    if (carry) carry_seen = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_value"},  32'(value),  32'h000);
    check({tag, "_carry"},  32'(carry),  32'h0);
    check({tag, "_en"},     32'(en),     32'b110);
    check({tag, "_seg"},    32'(seg),    32'b1000000);
    check({tag, "_value1"}, 32'(value1), 32'h0);
    check({tag, "_en1"},    32'(en1),    32'h0);
    check({tag, "_seg1"},   32'(seg1),   32'b1000000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    reset = 1'b1; cnt_en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 12'h000;
    carry_seen = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_init");
    #2 reset = 1'b0;

    // count up through 999 -> 000
    load = 1'b1; load_val = 12'h998; up_dn = 1'b1; cnt_en = 1'b1;
    cycle();
    load = 1'b0;
    repeat (8) cycle();
    check("up_wrap_value", 32'(value), 32'h000);
    check("up_wrap_carry", 32'(carry), 32'h1);
    cycle();
    check("up_carry_one_clk", 32'(carry), 32'h0);

    // count down with borrow
    load = 1'b1; load_val = 12'h100; up_dn = 1'b0;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    check("down_value", 32'(value), 32'h099);
    check("down_carry", 32'(carry), 32'h0);
    load = 1'b1; load_val = 12'h000;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    check("borrow_value", 32'(value), 32'h999);
    check("borrow_carry", 32'(carry), 32'h1);

    // load on the same edge as a tick; illegal digits sanitised
    guard = 0;
    while (m_tick != 3 && guard < 8) begin cycle(); guard++; end
    check("tick_align", 32'(m_tick), 32'd3);
    up_dn = 1'b1; load = 1'b1; load_val = 12'hA5F;
    cycle();
    load = 1'b0;
    check("load_sanitise", 32'(value), 32'h050);
    check("load_carry",    32'(carry), 32'h0);
    repeat (3) cycle();
    check("prescaler_restart_hold", 32'(value), 32'h050);
    cycle();
    check("prescaler_restart_tick", 32'(value), 32'h051);

    // enable low: ticks ignored
    cnt_en = 1'b0; carry_seen = 1'b0;
    repeat (40) cycle();
    check("hold_value",      32'(value),      32'h051);
    check("hold_no_carry",   32'(carry_seen), 32'h0);

    // scan 472 with aligned digit patterns
    load = 1'b1; load_val = 12'h472;
    cycle();
    load = 1'b0;
    repeat (12) begin
      cycle();
      case (en)
        3'b110: check("scan_d0", 32'(seg), 32'b0100100);
        3'b101: check("scan_d1", 32'(seg), 32'b1111000);
        3'b011: check("scan_d2", 32'(seg), 32'b0011001);
        default: check("scan_en_onehot", 32'(en), 32'b110);
      endcase
    end

    // asynchronous reset in the middle of counting and scanning
    cnt_en = 1'b1; up_dn = 1'b1;
    repeat (5) cycle();
    #2 reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(posedge clk); #1;
    check_reset_state("rst_held");
    #1 reset = 1'b0;
    model_reset();
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
